// File: rtl/tristate_bus_pkg.sv
// ============================================================================
// tristate_bus_pkg : shared types and defaults for the tri-state bus scheduler
// Revision 1.0
// ============================================================================
`default_nettype none

package tristate_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    DRIVE = 2'd2,
    GUARD = 2'd3
  } sched_state_t;

  localparam int N_DEF     = 4;
  localparam int HOLD_DEF  = 4;
  localparam int GUARD_DEF = 1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// rr_pick : combinational winner select, rotating from last+1 (FIXED_PRIORITY_EN
//           selects lowest-index instead). Revision 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import tristate_bus_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0]              req,
  input  logic [idx_width(N)-1:0]   last,
  output logic                      valid,
  output logic [idx_width(N)-1:0]   idx
);

  localparam int IW = idx_width(N);

`ifdef FIXED_PRIORITY_EN
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[IW'(i)]) idx = IW'(i);
    end
  end
`else
  // Scan downward so the nearest candidate after last is written last and wins.
  always_comb begin
    logic [IW-1:0] cand;
    valid = |req;
    idx   = '0;
    cand  = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % N);
      if (req[cand]) idx = cand;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/tristate_bus_sched.sv
// ============================================================================
// tristate_bus_sched : round-robin latch/OE sequencer for a shared tri-state
//                      bus (macro FIXED_PRIORITY_EN selects fixed priority).
// Revision 1.0
// ============================================================================
`default_nettype none

module tristate_bus_sched
  import tristate_bus_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int HOLD  = HOLD_DEF,
  parameter int GUARD = GUARD_DEF
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic [N-1:0]            req,
  output logic [N-1:0]            le,
  output logic [N-1:0]            oe,
  output logic [idx_width(N)-1:0] grant_id,
  output logic                    busy,
  output logic [N-1:0]            done
);

  localparam int IW      = idx_width(N);
  localparam int CNT_MAX = (HOLD > GUARD) ? HOLD : GUARD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [IW-1:0] GRANT_RST = IW'(N - 1);

  sched_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [N-1:0]  le_q, le_d, oe_q, oe_d, done_q, done_d;
  logic          busy_q, busy_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  owner_sel;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .last  (grant_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_sel = N'(1) << grant_q;

  // Outputs are computed for the state being entered so they appear registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    le_d    = '0;
    oe_d    = '0;
    done_d  = '0;
    unique case (state_q)
      tristate_bus_pkg::IDLE: begin
        if (pick_valid) begin
          state_d = tristate_bus_pkg::LATCH;
          grant_d = pick_idx;
          le_d    = N'(1) << pick_idx;
        end
      end
      tristate_bus_pkg::LATCH: begin
        state_d = tristate_bus_pkg::DRIVE;
        cnt_d   = CW'(HOLD - 1);
        oe_d    = owner_sel;
        if (HOLD == 1) done_d = owner_sel;
      end
      tristate_bus_pkg::DRIVE: begin
        if (cnt_q == '0) begin
          state_d = tristate_bus_pkg::GUARD;
          cnt_d   = CW'(GUARD - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
          oe_d  = owner_sel;
          if (cnt_q == CW'(1)) done_d = owner_sel;
        end
      end
      tristate_bus_pkg::GUARD: begin
        if (cnt_q == '0) state_d = tristate_bus_pkg::IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = tristate_bus_pkg::IDLE;
    endcase
    busy_d = (state_d != tristate_bus_pkg::IDLE);
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= tristate_bus_pkg::IDLE;
      cnt_q   <= '0;
      grant_q <= GRANT_RST;
      le_q    <= '0;
      oe_q    <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      le_q    <= le_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign le       = le_q;
  assign oe       = oe_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

`default_nettype wire
